// File: rtl/uart_tx.sv
// 8N1 UART transmitter, idle-high line, with a small power-of-two input FIFO.
// Frames go out back to back with no idle gap for as long as the FIFO holds data.
module uart_tx #(
  parameter int CLKS_PER_BIT = 1085,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       tx_out,
  output logic       busy,
  output logic       tx_done
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] LAST_CNT   = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] PENULT_CNT = CW'(CLKS_PER_BIT - 2);
  localparam logic [PW:0]   FULL_CNT   = (PW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bit;
  logic [7:0]    r_shift;
  logic          r_tx;
  logic          r_done;

  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_wr;
  logic [PW-1:0] r_rd;
  logic [PW:0]   r_count;

  logic          w_ready;
  logic          w_push;
  logic          w_pop;
  logic          w_bit_end;
  logic [7:0]    w_head;

  // Handshake: a byte moves when in_valid && in_ready at posedge clk; in_ready
  // depends only on the FIFO count, never on in_valid or on a same-cycle pop.
  assign w_ready   = (r_count != FULL_CNT);
  assign w_push    = in_valid && w_ready;
  assign w_bit_end = (r_cnt == LAST_CNT);
  assign w_pop     = (r_count != '0) &&
                     ((r_state == S_IDLE) || ((r_state == S_STOP) && w_bit_end));
  assign w_head    = r_mem[r_rd];

  assign in_ready = w_ready;
  assign tx_out   = r_tx;
  assign tx_done  = r_done;
  assign busy     = (r_state != S_IDLE) || (r_count != '0);

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= in_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + PW'(1);
      if (w_pop)  r_rd <= r_rd + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PW+1)'(1);
        2'b01:   r_count <= r_count - (PW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
      r_done  <= 1'b0;
    end else begin
      // Raised one cycle early so the pulse coincides with the last stop-bit cycle.
      r_done <= (r_state == S_STOP) && (r_cnt == PENULT_CNT);
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (w_pop) begin
            r_shift <= w_head;
            r_tx    <= 1'b0;
            r_state <= S_START;
          end else begin
            r_tx <= 1'b1;
          end
        end
        S_START: begin
          if (w_bit_end) begin
            r_cnt   <= '0;
            r_bit   <= '0;
            r_tx    <= r_shift[0];
            r_state <= S_DATA;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_DATA: begin
          if (w_bit_end) begin
            r_cnt <= '0;
            if (r_bit == 3'd7) begin
              r_tx    <= 1'b1;
              r_state <= S_STOP;
            end else begin
              r_shift <= r_shift >> 1;
              r_tx    <= r_shift[1];
              r_bit   <= r_bit + 3'd1;
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_STOP: begin
          if (w_bit_end) begin
            r_cnt <= '0;
            if (w_pop) begin
              r_shift <= w_head;
              r_tx    <= 1'b0;
              r_state <= S_START;
            end else begin
              r_state <= S_IDLE;
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: a fast instance (8 clk/bit) for framing and FIFO behaviour,
// and a default-rate instance (1085 clk/bit) for the real baud timing.
module tb_uart_tx;

  localparam int C  = 8;
  localparam int D  = 4;
  localparam int CD = 1085;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] d1_data = '0;
  logic       d1_valid = 1'b0;
  logic       d1_ready, d1_tx, d1_busy, d1_done;
  logic [7:0] d2_data = '0;
  logic       d2_valid = 1'b0;
  logic       d2_ready, d2_tx, d2_busy, d2_done;

  uart_tx #(.CLKS_PER_BIT(C), .FIFO_DEPTH(D)) u_fast (
    .clk(clk), .rst_n(rst_n), .in_data(d1_data), .in_valid(d1_valid),
    .in_ready(d1_ready), .tx_out(d1_tx), .busy(d1_busy), .tx_done(d1_done));

  uart_tx #(.CLKS_PER_BIT(CD), .FIFO_DEPTH(D)) u_slow (
    .clk(clk), .rst_n(rst_n), .in_data(d2_data), .in_valid(d2_valid),
    .in_ready(d2_ready), .tx_out(d2_tx), .busy(d2_busy), .tx_done(d2_done));

  int checks = 0;
  int errors = 0;

  // Recorder: one sample per cycle, taken on the falling edge.
  logic       rec_en = 1'b0;
  logic       sel2 = 1'b0;
  logic [0:0] line_q[$];
  logic [0:0] done_q[$];
  logic [0:0] busy_q[$];
  logic [0:0] rdy_q[$];
  logic [0:0] exp_line_q[$];
  logic [0:0] exp_done_q[$];
  logic [0:0] exp_busy_q[$];

  always @(negedge clk) begin
    if (rec_en) begin
      line_q.push_back(sel2 ? d2_tx    : d1_tx);
      done_q.push_back(sel2 ? d2_done  : d1_done);
      busy_q.push_back(sel2 ? d2_busy  : d1_busy);
      rdy_q.push_back (sel2 ? d2_ready : d1_ready);
    end
  end

  // Reference: after the push edge the line idles one more sample, then frames
  // (0, 8 data LSB first, 1) follow each other with no gap; tx_done marks the
  // last stop-bit cycle and busy holds from the push until that cycle.
  task automatic build_exp(input logic [7:0] bytes[$], input int cpb, input int total);
    logic v;
    exp_line_q.delete(); exp_done_q.delete(); exp_busy_q.delete();
    exp_line_q.push_back(1'b1); exp_done_q.push_back(1'b0); exp_busy_q.push_back(1'b0);
    exp_line_q.push_back(1'b1); exp_done_q.push_back(1'b0); exp_busy_q.push_back(1'b1);
    foreach (bytes[k]) begin
      for (int b = 0; b < 10; b++) begin
        v = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : bytes[k][b-1];
        for (int r = 0; r < cpb; r++) begin
          exp_line_q.push_back(v);
          exp_done_q.push_back((b == 9) && (r == cpb - 1));
          exp_busy_q.push_back(1'b1);
        end
      end
    end
    while (exp_line_q.size() < total) begin
      exp_line_q.push_back(1'b1); exp_done_q.push_back(1'b0); exp_busy_q.push_back(1'b0);
    end
  endtask

  task automatic diff_wave(input logic [0:0] a[$], input logic [0:0] b[$],
                           output int idx, output logic av, output logic bv);
    idx = -1; av = 1'bx; bv = 1'bx;
    for (int i = 0; i < a.size() && i < b.size(); i++) begin
      if (a[i] !== b[i]) begin
        idx = i; av = a[i]; bv = b[i];
        return;
      end
    end
    if (a.size() != b.size()) idx = (a.size() < b.size()) ? a.size() : b.size();
  endtask

  task automatic start_rec(input bit to2);
    line_q.delete(); done_q.delete(); busy_q.delete(); rdy_q.delete();
    sel2 = to2;
    @(posedge clk); #1;
    rec_en = 1'b1;
  endtask

  task automatic push_byte(input logic [7:0] b, input bit to2);
    int guard = 0;
    if (to2) begin d2_valid = 1'b1; d2_data = b; end
    else     begin d1_valid = 1'b1; d1_data = b; end
    @(negedge clk);
    while (!(to2 ? d2_ready : d1_ready) && guard < 5000) begin
      guard++;
      @(negedge clk);
    end
    if (guard >= 5000) begin
      checks++; errors++;
      $display("FAIL push_timeout: in_ready stayed %b, required 1", 1'b0);
    end
    @(posedge clk); #1;
    if (to2) begin d2_valid = 1'b0; d2_data = 8'($urandom); end
    else     begin d1_valid = 1'b0; d1_data = 8'($urandom); end
  endtask

  task automatic play_bytes(input logic [7:0] bytes[$], input bit to2);
    int g = 0;
    int cpb = to2 ? CD : C;
    start_rec(to2);
    foreach (bytes[k]) push_byte(bytes[k], to2);
    while ((to2 ? d2_busy : d1_busy) && g < 30000) begin
      g++;
      @(negedge clk);
    end
    if (g >= 30000) begin
      checks++; errors++;
      $display("FAIL idle_timeout: busy still 1 after %0d cycles, required 0", g);
    end
    repeat (10) @(negedge clk);
    @(posedge clk); #1;
    rec_en = 1'b0;
    build_exp(bytes, cpb, line_q.size());
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if ({d1_tx, d1_busy, d1_ready, d1_done} !== 4'b1010) begin
      errors++;
      $display("FAIL reset_fast: tx/busy/ready/done got %b required 1010",
               {d1_tx, d1_busy, d1_ready, d1_done});
    end
    checks++;
    if ({d2_tx, d2_busy, d2_ready, d2_done} !== 4'b1010) begin
      errors++;
      $display("FAIL reset_slow: tx/busy/ready/done got %b required 1010",
               {d2_tx, d2_busy, d2_ready, d2_done});
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if ({d1_tx, d1_busy, d1_ready, d1_done} !== 4'b1010) begin
      errors++;
      $display("FAIL idle_after_reset: tx/busy/ready/done got %b required 1010",
               {d1_tx, d1_busy, d1_ready, d1_done});
    end
  endtask

  task automatic test_single;
    logic [7:0] bytes[$];
    int idx; logic av, bv;
    bytes = '{8'h55};
    play_bytes(bytes, 1'b0);
    checks++; diff_wave(line_q, exp_line_q, idx, av, bv);
    if (idx != -1) begin errors++; $display("FAIL single_line: sample %0d got %b required %b", idx, av, bv); end
    checks++; diff_wave(done_q, exp_done_q, idx, av, bv);
    if (idx != -1) begin errors++; $display("FAIL single_done: sample %0d got %b required %b", idx, av, bv); end
    checks++; diff_wave(busy_q, exp_busy_q, idx, av, bv);
    if (idx != -1) begin errors++; $display("FAIL single_busy: sample %0d got %b required %b", idx, av, bv); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] bytes[$];
    int idx; logic av, bv;
    bytes = '{8'h00, 8'hFF};
    play_bytes(bytes, 1'b0);
    checks++; diff_wave(line_q, exp_line_q, idx, av, bv);
    if (idx != -1) begin errors++; $display("FAIL b2b_line: sample %0d got %b required %b", idx, av, bv); end
    checks++; diff_wave(done_q, exp_done_q, idx, av, bv);
    if (idx != -1) begin errors++; $display("FAIL b2b_done: sample %0d got %b required %b", idx, av, bv); end
    checks++; diff_wave(busy_q, exp_busy_q, idx, av, bv);
    if (idx != -1) begin errors++; $display("FAIL b2b_busy: sample %0d got %b required %b", idx, av, bv); end
  endtask

  task automatic test_fifo_full;
    logic [7:0] bytes[$];
    int idx; logic av, bv;
    int bad_rdy = -1;
    for (int i = 0; i < 6; i++) bytes.push_back(8'($urandom));
    play_bytes(bytes, 1'b0);
    checks++; diff_wave(line_q, exp_line_q, idx, av, bv);
    if (idx != -1) begin errors++; $display("FAIL full_line: sample %0d got %b required %b", idx, av, bv); end
    checks++; diff_wave(done_q, exp_done_q, idx, av, bv);
    if (idx != -1) begin errors++; $display("FAIL full_done: sample %0d got %b required %b", idx, av, bv); end
    checks++; diff_wave(busy_q, exp_busy_q, idx, av, bv);
    if (idx != -1) begin errors++; $display("FAIL full_busy: sample %0d got %b required %b", idx, av, bv); end
    // Full from the fifth push until the first stop-bit ends, ready again one cycle later.
    for (int i = 0; i <= 2 + 10 * C && i < rdy_q.size(); i++) begin
      if (bad_rdy == -1 && rdy_q[i] !== ((i >= 5 && i <= 1 + 10 * C) ? 1'b0 : 1'b1)) bad_rdy = i;
    end
    checks++;
    if (bad_rdy != -1) begin
      errors++;
      $display("FAIL full_ready: sample %0d got %b required %b", bad_rdy, rdy_q[bad_rdy],
               (bad_rdy >= 5 && bad_rdy <= 1 + 10 * C) ? 1'b0 : 1'b1);
    end
  endtask

  task automatic test_random_burst;
    logic [7:0] bytes[$];
    int idx; logic av, bv;
    int n = $urandom_range(2, 5);
    for (int i = 0; i < n; i++) bytes.push_back(8'($urandom));
    play_bytes(bytes, 1'b0);
    checks++; diff_wave(line_q, exp_line_q, idx, av, bv);
    if (idx != -1) begin errors++; $display("FAIL burst_line: sample %0d got %b required %b", idx, av, bv); end
    checks++; diff_wave(done_q, exp_done_q, idx, av, bv);
    if (idx != -1) begin errors++; $display("FAIL burst_done: sample %0d got %b required %b", idx, av, bv); end
  endtask

  task automatic test_reset_mid_frame;
    logic [7:0] b0;
    int n_low = 0, n_done = 0, n_busy = 0;
    b0 = 8'($urandom) & 8'hF7;
    @(posedge clk); #1;
    push_byte(b0, 1'b0);
    push_byte(8'($urandom), 1'b0);
    push_byte(8'($urandom), 1'b0);
    repeat (4 * C + 1) @(posedge clk);
    #2;
    checks++;
    if ({d1_tx, d1_busy} !== 2'b01) begin
      errors++;
      $display("FAIL pre_reset_bit3: tx/busy got %b required 01", {d1_tx, d1_busy});
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({d1_tx, d1_busy, d1_ready, d1_done} !== 4'b1010) begin
      errors++;
      $display("FAIL async_reset: tx/busy/ready/done got %b required 1010",
               {d1_tx, d1_busy, d1_ready, d1_done});
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    start_rec(1'b0);
    repeat (1000) @(negedge clk);
    #1;
    rec_en = 1'b0;
    foreach (line_q[i]) begin
      if (line_q[i] !== 1'b1) n_low++;
      if (done_q[i] !== 1'b0) n_done++;
      if (busy_q[i] !== 1'b0) n_busy++;
    end
    checks++;
    if (n_low != 0 || n_done != 0 || n_busy != 0 || line_q.size() < 1000) begin
      errors++;
      $display("FAIL post_reset_idle: low=%0d done=%0d busy=%0d samples=%0d required 0/0/0/1000",
               n_low, n_done, n_busy, line_q.size());
    end
  endtask

  task automatic test_default_rate;
    logic [7:0] bytes[$];
    logic [7:0] mid;
    logic [7:0] want;
    int idx; logic av, bv;
    bytes = '{8'hA3};
    want = 8'b1010_0011;
    play_bytes(bytes, 1'b1);
    checks++; diff_wave(line_q, exp_line_q, idx, av, bv);
    if (idx != -1) begin errors++; $display("FAIL rate_line: sample %0d got %b required %b", idx, av, bv); end
    checks++; diff_wave(done_q, exp_done_q, idx, av, bv);
    if (idx != -1) begin errors++; $display("FAIL rate_done: sample %0d got %b required %b", idx, av, bv); end
    mid = '0;
    for (int i = 0; i < 8; i++) begin
      if (2 + CD * (i + 1) + CD / 2 < line_q.size()) mid[i] = line_q[2 + CD * (i + 1) + CD / 2];
    end
    checks++;
    if (mid !== want) begin
      errors++;
      $display("FAIL rate_midbit: sampled %h required %h", mid, want);
    end
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_fifo_full();
    test_random_burst();
    test_reset_mid_frame();
    test_default_rate();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
UART transmitter, 8N1 framing (1 start bit, 8 data bits LSB first, 1 stop bit), idle-high line.
Default baud is 115200 at a 125 MHz clk.
A small input FIFO decouples byte producers (e.g. the RPN result formatter) from the serial line.
It sits opposite uart_rx on the board's serial link.

Parameters:
CLKS_PER_BIT, 1085, clk cycles per serial bit (125 MHz / 115200); legal range >= 2.
FIFO_DEPTH, 4, input FIFO entries; power of 2, >= 2.

Ports:
clk  input  1  system clock, 125 MHz nominal; all logic on posedge.
rst_n  input  1  asynchronous active-low reset.
in_data  input  8  byte to transmit.
in_valid  input  1  in_data valid; byte accepted on posedge clk when in_valid && in_ready.
in_ready  output  1  FIFO not full; combinational from FIFO count only, independent of in_valid.
tx_out  output  1  serial line, registered, idle 1.
busy  output  1  high while a frame is on the line or the FIFO is non-empty.
tx_done  output  1  one-cycle pulse at the end of each frame's stop bit.

Behaviour:
- Reset (rst_n low, asynchronous): tx_out=1, tx_done=0, busy=0, FIFO emptied (in_ready=1), state IDLE, bit and cycle counters 0.
- Reset asserted mid-frame aborts the frame: tx_out returns to 1 immediately, no tx_done, queued bytes discarded. After release, the first frame starts no earlier than the first posedge with rst_n high.
- FIFO push:
  - Occurs on posedge when in_valid && in_ready.
  - in_ready=0 when count==FIFO_DEPTH, even if a pop happens the same cycle; in that case the push is not taken and the producer holds in_valid and in_data.
  - Push and pop on the same edge (non-full) are both honoured; count is unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- State machine (registered): IDLE, START, DATA, STOP.
  - IDLE: if count!=0 on a posedge, pop the head into an 8-bit shift register, set tx_out=0, clear cycle counter, go START. Otherwise tx_out stays 1.
  - START: hold tx_out=0 for exactly CLKS_PER_BIT cycles. On the last cycle, drive tx_out=shift[0] and go DATA with bit index 0.
  - DATA: each bit is held for exactly CLKS_PER_BIT cycles, then the register shifts right. After bit 7's period, tx_out=1 and go STOP.
  - STOP: hold tx_out=1 for CLKS_PER_BIT cycles. On the final cycle, tx_done=1 for one clk:
    - if count!=0, pop the next byte, tx_out=0, go START (back-to-back, no idle gap);
    - else go IDLE.
- Frame length is exactly 10*CLKS_PER_BIT cycles measured from the tx_out falling edge. Bit boundaries never drift and there are no extra cycles between consecutive frames.
- Latency: a byte pushed into an empty FIFO while IDLE on edge N gives tx_out=0 after edge N+1.
- Cycle counter width is clog2(CLKS_PER_BIT); it counts 0..CLKS_PER_BIT-1 and wraps to 0 at each bit boundary.
- busy = (state!=IDLE) || (count!=0). It is registered-equivalent, with no glitches on the edge where IDLE pops.
- in_data is sampled only at push; changes while not pushing have no effect.
- A FIFO holding FIFO_DEPTH bytes plus one byte in the shifter means up to FIFO_DEPTH+1 bytes are in flight.

Test Plan:
- Single byte (CLKS_PER_BIT=8): push 0x55 at edge N while IDLE.
  -> tx_out 0 for cycles N+1..N+8, then bits 1,0,1,0,1,0,1,0 at 8 cycles each, then stop 1 for 8 cycles.
  -> tx_done pulses once at cycle N+80; busy falls the next cycle.
- Back-to-back: push 0x00 then 0xFF on consecutive edges.
  -> 0x00 frame followed immediately by the 0xFF frame: no idle cycle, 160 cycles total, two tx_done pulses exactly 80 cycles apart.
- FIFO full (FIFO_DEPTH=4, CLKS_PER_BIT=8): hold in_valid=1 for 6 consecutive bytes A..F from edge N.
  -> A popped at N+1; B–E accepted; in_ready=0 from after N+4 until the first pop at A's stop end; F accepted then.
  -> Line carries A..F in order with no gaps.
- Reset mid-frame: assert rst_n=0 during DATA bit 3 with 2 bytes queued.
  -> tx_out=1 asynchronously, in_ready=1, busy=0, no tx_done.
  -> After release with no new pushes, the line stays 1 for 1000 cycles.
- Default rate: CLKS_PER_BIT=1085, push 0xA3.
  -> Bit period measured 1085 cycles (8680 ns) for every bit; sampled data 1,1,0,0,0,1,0,1 LSB first; frame 10850 cycles.
